// File: rtl/paddle_controller_if.sv
// Signal bundle between the paddle controller and its keyboard and render neighbours.
// The bundle has no valid/ready pair: inputs are level signals, and tick is a one-cycle strobe with no back-pressure.
interface paddle_controller_if;
   logic       gameClk;
   logic [6:0] inputBits;
   logic [9:0] leftPaddleY;
   logic [9:0] rightPaddleY;
   logic [1:0] speedLevel;
   logic [3:0] ballStep;
   logic       tick;

   modport master (
      output gameClk, inputBits,
      input  leftPaddleY, rightPaddleY, speedLevel, ballStep, tick
   );

   modport slave (
      input  gameClk, inputBits,
      output leftPaddleY, rightPaddleY, speedLevel, ballStep, tick
   );
endinterface

// File: rtl/paddle_controller.sv
// Paddle controller: input synchronisers, speed-level FSM, and per-tick clamped paddle motion.
// Optional hold-to-accelerate behaviour is enabled by defining PADDLE_ACCEL_EN.
module paddle_controller #(
   parameter int SCREEN_H  = 480,
   parameter int PADDLE_H  = 80,
   parameter int Y_INIT    = 200,
   parameter int STEP_SLOW = 2,
   parameter int STEP_MID  = 4,
   parameter int STEP_FAST = 8
`ifdef PADDLE_ACCEL_EN
   ,
   parameter int ACCEL_TICKS = 16
`endif
) (
   input logic                CLOCK_50,
   input logic                resetN,
   paddle_controller_if.slave bus
);

   localparam logic [10:0] Y_MAX   = 11'(SCREEN_H - PADDLE_H);
   localparam logic [9:0]  Y_START = 10'(Y_INIT);

   typedef enum logic [1:0] {
      SPD_SLOW = 2'd0,
      SPD_MID  = 2'd1,
      SPD_FAST = 2'd2
   } speed_e;

   speed_e     r_state;
   speed_e     w_next_state;

   logic       r_gclk_s1, r_gclk_s2, r_gclk_s3;
   logic       r_tick;
   logic [6:0] r_in_s1, r_in_s2;
   logic [2:0] r_spd_d;
   logic [2:0] w_spd_rise;
   logic [3:0] r_ball_step;
   logic [9:0] r_left_y, r_right_y;
   logic [4:0] w_cur_step;
   logic [4:0] w_l_step, w_r_step;
   logic [9:0] w_left_new, w_right_new;
   logic       w_l_up, w_l_dn, w_r_up, w_r_dn;

   function automatic logic [3:0] step_of(input speed_e s);
      case (s)
         SPD_SLOW: step_of = 4'(STEP_SLOW);
         SPD_FAST: step_of = 4'(STEP_FAST);
         default:  step_of = 4'(STEP_MID);
      endcase
   endfunction

   // Widened to 11 bits so the down-move sum can never wrap before the clamp compare.
   function automatic logic [9:0] move_y(input logic [9:0] y, input logic up,
                                         input logic dn, input logic [4:0] step);
      logic [10:0] y_w, s_w, sum;
      y_w = {1'b0, y};
      s_w = {6'd0, step};
      sum = y_w + s_w;
      move_y = y;
      if (up && !dn) begin
         move_y = (y_w < s_w) ? 10'd0 : 10'(y_w - s_w);
      end else if (dn && !up) begin
         move_y = (sum > Y_MAX) ? 10'(Y_MAX) : 10'(sum);
      end
   endfunction

   assign w_l_up     = r_in_s2[6];
   assign w_l_dn     = r_in_s2[5];
   assign w_r_up     = r_in_s2[4];
   assign w_r_dn     = r_in_s2[3];
   assign w_spd_rise = r_in_s2[2:0] & ~r_spd_d;
   assign w_cur_step = {1'b0, step_of(r_state)};

   // Speed FSM state register.
   always_ff @(posedge CLOCK_50) begin
      if (!resetN) begin
         r_state <= SPD_MID;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Edge priority: up over mid over down; held levels produce no edge.
   always_comb begin
      w_next_state = r_state;
      if (w_spd_rise[2]) begin
         case (r_state)
            SPD_SLOW: w_next_state = SPD_MID;
            default:  w_next_state = SPD_FAST;
         endcase
      end else if (w_spd_rise[1]) begin
         w_next_state = SPD_MID;
      end else if (w_spd_rise[0]) begin
         case (r_state)
            SPD_FAST: w_next_state = SPD_MID;
            default:  w_next_state = SPD_SLOW;
         endcase
      end
   end

`ifdef PADDLE_ACCEL_EN
   localparam logic [4:0] ACCEL_MAX = 5'(ACCEL_TICKS);

   logic [4:0] r_l_cnt, r_r_cnt;
   logic [1:0] r_l_dir, r_r_dir;
   logic [1:0] w_l_dir, w_r_dir;

   // A tick that starts a new direction is itself the first held tick of that run.
   function automatic logic [4:0] hold_next(input logic [1:0] dir, input logic [1:0] prev,
                                            input logic [4:0] cnt);
      if (dir == 2'd0) begin
         hold_next = 5'd0;
      end else if (dir != prev) begin
         hold_next = 5'd1;
      end else if (cnt >= ACCEL_MAX) begin
         hold_next = ACCEL_MAX;
      end else begin
         hold_next = cnt + 5'd1;
      end
   endfunction

   assign w_l_dir  = {w_l_dn & ~w_l_up, w_l_up & ~w_l_dn};
   assign w_r_dir  = {w_r_dn & ~w_r_up, w_r_up & ~w_r_dn};
   assign w_l_step = (r_l_cnt == ACCEL_MAX) ? {w_cur_step[3:0], 1'b0} : w_cur_step;
   assign w_r_step = (r_r_cnt == ACCEL_MAX) ? {w_cur_step[3:0], 1'b0} : w_cur_step;

   always_ff @(posedge CLOCK_50) begin
      if (!resetN) begin
         r_l_cnt <= 5'd0;
         r_r_cnt <= 5'd0;
         r_l_dir <= 2'd0;
         r_r_dir <= 2'd0;
      end else if (r_tick) begin
         r_l_cnt <= hold_next(w_l_dir, r_l_dir, r_l_cnt);
         r_r_cnt <= hold_next(w_r_dir, r_r_dir, r_r_cnt);
         r_l_dir <= w_l_dir;
         r_r_dir <= w_r_dir;
      end
   end
`else
   assign w_l_step = w_cur_step;
   assign w_r_step = w_cur_step;
`endif

   assign w_left_new  = move_y(r_left_y, w_l_up, w_l_dn, w_l_step);
   assign w_right_new = move_y(r_right_y, w_r_up, w_r_dn, w_r_step);

   always_ff @(posedge CLOCK_50) begin
      if (!resetN) begin
         r_gclk_s1   <= 1'b0;
         r_gclk_s2   <= 1'b0;
         r_gclk_s3   <= 1'b0;
         r_tick      <= 1'b0;
         r_in_s1     <= 7'd0;
         r_in_s2     <= 7'd0;
         r_spd_d     <= 3'd0;
         r_ball_step <= 4'(STEP_MID);
         r_left_y    <= Y_START;
         r_right_y   <= Y_START;
      end else begin
         r_gclk_s1   <= bus.gameClk;
         r_gclk_s2   <= r_gclk_s1;
         r_gclk_s3   <= r_gclk_s2;
         r_tick      <= r_gclk_s2 & ~r_gclk_s3;
         r_in_s1     <= bus.inputBits;
         r_in_s2     <= r_in_s1;
         r_spd_d     <= r_in_s2[2:0];
         r_ball_step <= step_of(w_next_state);
         // Move uses the step of the current state even if the speed changes this cycle.
         if (r_tick) begin
            r_left_y  <= w_left_new;
            r_right_y <= w_right_new;
         end
      end
   end

   assign bus.leftPaddleY  = r_left_y;
   assign bus.rightPaddleY = r_right_y;
   assign bus.speedLevel   = r_state;
   assign bus.ballStep     = r_ball_step;
   assign bus.tick         = r_tick;

endmodule

// File: tb/tb_paddle_controller.sv
// Directed bench for paddle_controller with a queue of expected paddle positions per tick.
module tb_paddle_controller;
   logic clk;
   logic resetN;
   paddle_controller_if pif ();

   paddle_controller dut (
      .CLOCK_50 (clk),
      .resetN   (resetN),
      .bus      (pif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [19:0] exp_q[$];
   logic [6:0]  keys;
   int m_left, m_right, m_level;
   int m_lcnt, m_rcnt, m_lprev, m_rprev;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   function automatic int lvl_step(input int lvl);
      if (lvl == 0) return 2;
      if (lvl == 2) return 8;
      return 4;
   endfunction

   function automatic int mdl_move(input int y, input bit up, input bit dn, input int st);
      if (up && !dn) return (y < st) ? 0 : y - st;
      if (dn && !up) return (y + st > 400) ? 400 : y + st;
      return y;
   endfunction

   function automatic int dir_of(input bit up, input bit dn);
      if (up && !dn) return 1;
      if (dn && !up) return 2;
      return 0;
   endfunction

   function automatic int cnt_next(input int dir, input int prev, input int cnt);
      if (dir == 0) return 0;
      if (dir != prev) return 1;
      return (cnt >= 16) ? 16 : cnt + 1;
   endfunction

   task automatic model_tick();
      int st, lst, rst;
      st  = lvl_step(m_level);
      lst = st;
      rst = st;
`ifdef PADDLE_ACCEL_EN
      if (m_lcnt == 16) lst = 2 * st;
      if (m_rcnt == 16) rst = 2 * st;
      m_lcnt  = cnt_next(dir_of(keys[6], keys[5]), m_lprev, m_lcnt);
      m_rcnt  = cnt_next(dir_of(keys[4], keys[3]), m_rprev, m_rcnt);
      m_lprev = dir_of(keys[6], keys[5]);
      m_rprev = dir_of(keys[4], keys[3]);
`endif
      m_left  = mdl_move(m_left, keys[6], keys[5], lst);
      m_right = mdl_move(m_right, keys[4], keys[3], rst);
      exp_q.push_back({10'(m_left), 10'(m_right)});
   endtask

   // Called just after a falling clock edge.
   task automatic do_tick();
      int n;
      logic [19:0] e;
      model_tick();
      pif.gameClk = 1'b1;
      n = 0;
      while (pif.tick !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("tick_latency", n, 3);
      @(negedge clk);
      check("tick_width", pif.tick, 0);
      e = exp_q.pop_front();
      check("left_y", pif.leftPaddleY, e[19:10]);
      check("right_y", pif.rightPaddleY, e[9:0]);
      pif.gameClk = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) do_tick();
   endtask

   task automatic set_keys(input logic [6:0] k);
      keys = k;
      pif.inputBits = k;
      repeat (3) @(negedge clk);
   endtask

   task automatic spd_pulse(input logic [2:0] b);
      pif.inputBits = keys | {4'd0, b};
      if (b[2]) m_level = (m_level < 2) ? m_level + 1 : 2;
      else if (b[1]) m_level = 1;
      else if (b[0]) m_level = (m_level > 0) ? m_level - 1 : 0;
      repeat (3) @(negedge clk);
      pif.inputBits = keys;
      repeat (3) @(negedge clk);
      check("speed_level", pif.speedLevel, m_level);
      check("ball_step", pif.ballStep, lvl_step(m_level));
   endtask

   task automatic do_reset();
      resetN = 1'b0;
      pif.gameClk = 1'b0;
      keys = 7'd0;
      pif.inputBits = 7'd0;
      repeat (3) @(negedge clk);
      resetN = 1'b1;
      m_left = 200; m_right = 200; m_level = 1;
      m_lcnt = 0; m_rcnt = 0; m_lprev = 0; m_rprev = 0;
      @(negedge clk);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      do_reset();
      check("rst_left", pif.leftPaddleY, 200);
      check("rst_right", pif.rightPaddleY, 200);
      check("rst_speed", pif.speedLevel, 1);
      check("rst_ballstep", pif.ballStep, 4);
      check("rst_tick", pif.tick, 0);

      // Idle ticks.
      ticks(5);

      // Left up at MID.
      set_keys(7'b1000000);
      ticks(10);
      check("t2_left", pif.leftPaddleY, 160);
      check("t2_right", pif.rightPaddleY, 200);

      // Right down at FAST, clamping at the bottom limit.
      spd_pulse(3'b100);
      set_keys(7'b0001000);
      ticks(200);
      check("t3_right_clamp", pif.rightPaddleY, 400);

      // Left up to the top limit, including a step larger than the remaining distance.
      spd_pulse(3'b010);
      set_keys(7'b1000000);
      ticks(39);
      check("t3_left_4", pif.leftPaddleY, 4);
      spd_pulse(3'b001);
      ticks(1);
      check("t3_left_2", pif.leftPaddleY, 2);
      spd_pulse(3'b010);
      ticks(1);
      check("t3_left_0", pif.leftPaddleY, 0);
      ticks(2);

      // Both keys on one paddle hold position.
      set_keys(7'b0011000);
      ticks(2);
      set_keys(7'd0);

      // Speed saturation and same-cycle edge priority.
      spd_pulse(3'b100);
      spd_pulse(3'b100);
      spd_pulse(3'b100);
      check("t4_fast", pif.speedLevel, 2);
      spd_pulse(3'b001);
      spd_pulse(3'b001);
      spd_pulse(3'b001);
      check("t4_slow_step", pif.ballStep, 2);
      spd_pulse(3'b010);
      spd_pulse(3'b101);
      check("t4_both_edges", pif.speedLevel, 2);

      // Reset in the tick cycle overrides the move.
      do_reset();
      set_keys(7'b1000000);
      ticks(20);
      check("t5_left_120", pif.leftPaddleY, 120);
      pif.gameClk = 1'b1;
      n = 0;
      while (pif.tick !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("t5_tick_seen", pif.tick, 1);
      resetN = 1'b0;
      pif.gameClk = 1'b0;
      keys = 7'd0;
      pif.inputBits = 7'd0;
      @(negedge clk);
      check("t5_left", pif.leftPaddleY, 200);
      check("t5_speed", pif.speedLevel, 1);
      check("t5_tick", pif.tick, 0);
      do_reset();

`ifdef PADDLE_ACCEL_EN
      // Hold-to-accelerate.
      set_keys(7'b1000000);
      ticks(40);
      check("t6_left_0", pif.leftPaddleY, 0);
      set_keys(7'd0);
      ticks(1);
      set_keys(7'b0100000);
      ticks(20);
      check("t6_left_96", pif.leftPaddleY, 96);
      set_keys(7'd0);
      ticks(1);
      set_keys(7'b0100000);
      ticks(1);
      check("t6_left_100", pif.leftPaddleY, 100);
      set_keys(7'd0);
`endif

      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
